// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// FSM state encoding, frame width and the baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned BAUD_CNT_W = 32;
  localparam int unsigned BIT_IDX_W  = 3;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Clock cycles per bit, integer-truncated so TX and RX agree exactly.
  function automatic int unsigned divisor(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake plus serial line and status flags of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  uart_byte_t tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_serial,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_serial,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIVISOR-1 and flags the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(DIVISOR - 1);

  logic [BAUD_CNT_W-1:0] count;
  logic [BAUD_CNT_W-1:0] count_next;

  // Wrap at the bit boundary or restart on a new frame.
  always_comb begin
    count_next = count + BAUD_CNT_W'(1);
    if (clear || (count == LAST)) begin
      count_next = '0;
    end
  end

  // tick is registered from the next count so it is high exactly while count==LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= count_next;
      tick  <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends it
// LSB-first with start bit, optional parity and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  tx
);

  localparam int unsigned DIVISOR = divisor(CLK_FREQ, BAUD_RATE);

  localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(STOP_BITS - 1);

  generate
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  state_t               state;
  state_t               state_next;
  uart_byte_t           shifter;
  uart_byte_t           shifter_next;
  logic [BIT_IDX_W-1:0] bit_index;
  logic [BIT_IDX_W-1:0] bit_index_next;
  logic                 parity_bit;
  logic                 parity_next;
  logic                 serial;
  logic                 serial_next;
  logic                 ready;
  logic                 ready_next;
  logic                 busy;
  logic                 busy_next;
  logic                 done;
  logic                 done_next;
  logic                 clear_c;
  logic                 tick;

  uart_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_c),
    .tick  (tick)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shifter    <= '0;
      bit_index  <= '0;
      parity_bit <= 1'b0;
      serial     <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shifter    <= shifter_next;
      bit_index  <= bit_index_next;
      parity_bit <= parity_next;
      serial     <= serial_next;
      ready      <= ready_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Next-state and next-output logic; serial_next is the level for the coming bit.
  always_comb begin
    state_next     = state;
    shifter_next   = shifter;
    bit_index_next = bit_index;
    parity_next    = parity_bit;
    serial_next    = serial;
    ready_next     = ready;
    busy_next      = busy;
    done_next      = 1'b0;
    clear_c        = 1'b0;

    case (state)
      IDLE: begin
        serial_next = 1'b1;
        ready_next  = 1'b1;
        busy_next   = 1'b0;
        if (tx.tx_valid && ready) begin
          shifter_next   = tx.tx_data;
          parity_next    = (PARITY_ODD != 0) ? ~^tx.tx_data : ^tx.tx_data;
          bit_index_next = '0;
          clear_c        = 1'b1;
          state_next     = START;
          serial_next    = 1'b0;
          ready_next     = 1'b0;
          busy_next      = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_next  = DATA;
          serial_next = shifter[0];
        end
      end

      DATA: begin
        if (tick) begin
          shifter_next   = shifter >> 1;
          bit_index_next = bit_index + BIT_IDX_W'(1);
          if (bit_index == LAST_DATA_IDX) begin
            bit_index_next = '0;
            if (PARITY_EN != 0) begin
              state_next  = PARITY;
              serial_next = parity_bit;
            end else begin
              state_next  = STOP;
              serial_next = 1'b1;
            end
          end else begin
            serial_next = shifter[1];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_next  = STOP;
          serial_next = 1'b1;
        end
      end

      STOP: begin
        // bit_index counts stop bits already sent.
        if (tick) begin
          if (bit_index == LAST_STOP_IDX) begin
            state_next     = IDLE;
            bit_index_next = '0;
            done_next      = 1'b1;
            ready_next     = 1'b1;
            busy_next      = 1'b0;
          end else begin
            bit_index_next = bit_index + BIT_IDX_W'(1);
          end
        end
      end

      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        ready_next  = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

  assign tx.tx_serial = serial;
  assign tx.tx_ready  = ready;
  assign tx.tx_busy   = busy;
  assign tx.tx_done   = done;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: four parameter variants at DIVISOR=10, a serial
// receiver model on the 8N1 instance scoreboarding every transmitted byte.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned CF  = 1_000_000;
  localparam int unsigned BR  = 100_000;
  localparam int          DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [DATA_BITS-1:0] q0[$];
  int                   rx_frames = 0;

  uart_tx_if b0();
  uart_tx_if b1();
  uart_tx_if b2();
  uart_tx_if b3();

  uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .tx(b0));
  uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .tx(b1));
  uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst(rst), .tx(b2));
  uart_tx #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut3 (.clk(clk), .rst(rst), .tx(b3));

  always #5 clk = ~clk;

  // Expected line level for frame bit idx: 0 start, 1..8 data, then parity, then stop.
  function automatic logic frame_bit(input logic [7:0] d, input int pe, input int po, input int idx);
    logic odd_ones;
    odd_ones = ($countones(d) % 2) == 1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if ((pe != 0) && (idx == 9)) return (po != 0) ? !odd_ones : odd_ones;
    return 1'b1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Receiver model: samples mid-bit on the falling edge and pops the scoreboard.
  initial begin : rx_model
    logic                 act;
    int                   cnt;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] expd;
    act = 1'b0;
    cnt = 0;
    sh  = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (b0.tx_serial === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == DIV/2) begin
          checks++;
          if (b0.tx_serial !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_bit got %b expected 0", b0.tx_serial);
          end
        end else if ((cnt % DIV) == DIV/2 && cnt < 9*DIV) begin
          sh[cnt/DIV - 1] = b0.tx_serial;
        end else if (cnt == 9*DIV + DIV/2) begin
          act = 1'b0;
          rx_frames++;
          checks++;
          if (b0.tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL rx_stop_bit got %b expected 1", b0.tx_serial);
          end
          checks++;
          if (q0.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected_frame got %02h expected none", sh);
          end else begin
            expd = q0.pop_front();
            if (sh !== expd) begin
              errors++;
              $display("FAIL rx_data got %02h expected %02h", sh, expd);
            end
          end
        end
      end
    end
  end

  // Sends one byte on instance 0 and returns cycles from handshake to tx_done.
  task automatic send0(input logic [7:0] d, output int lat);
    for (int k = 0; k < 300 && b0.tx_ready !== 1'b1; k++) cycle();
    b0.tx_data  = d;
    b0.tx_valid = 1'b1;
    cycle();
    b0.tx_valid = 1'b0;
    q0.push_back(d);
    lat = -1;
    for (int j = 1; j <= 300; j++) begin
      cycle();
      if (b0.tx_done === 1'b1) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    repeat (3) cycle();
    checks++; if (b0.tx_serial !== 1'b1) begin errors++; $display("FAIL reset_serial got %b expected 1", b0.tx_serial); end
    checks++; if (b0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b expected 1", b0.tx_ready); end
    checks++; if (b0.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", b0.tx_busy); end
    checks++; if (b0.tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", b0.tx_done); end
    checks++; if (b3.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_stop2 got %b expected 1", b3.tx_ready); end
    rst = 1'b0;
    repeat (2) cycle();

    b0.tx_data  = 8'hFF;
    b0.tx_valid = 1'b1;
    cycle();
    b0.tx_valid = 1'b0;
    q0.push_back(8'hFF);
    checks++; if (b0.tx_ready !== 1'b0 || b0.tx_busy !== 1'b1) begin
      errors++; $display("FAIL handshake_flags got ready=%b busy=%b expected ready=0 busy=1", b0.tx_ready, b0.tx_busy);
    end
    checks++; if (b0.tx_serial !== 1'b0) begin errors++; $display("FAIL start_bit_level got %b expected 0", b0.tx_serial); end

    repeat (35) cycle();
    #2 rst = 1'b1;
    #1;
    checks++; if (b0.tx_serial !== 1'b1) begin errors++; $display("FAIL async_reset_serial got %b expected 1", b0.tx_serial); end
    checks++; if (b0.tx_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b expected 1", b0.tx_ready); end
    checks++; if (b0.tx_busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b expected 0", b0.tx_busy); end
    repeat (2) begin
      cycle();
      checks++; if (b0.tx_done !== 1'b0) begin errors++; $display("FAIL reset_no_done got %b expected 0", b0.tx_done); end
    end
    rst = 1'b0;
    q0.delete();
    repeat (3) cycle();

    send0(8'h0F, lat);
    checks++; if (lat != 100) begin errors++; $display("FAIL after_reset_latency got %0d expected 100", lat); end
  endtask

  task automatic test_single_byte();
    logic bad_ctl;
    logic expb;
    bad_ctl = 1'b0;
    b0.tx_data  = 8'hA5;
    b0.tx_valid = 1'b1;
    cycle();
    b0.tx_valid = 1'b0;
    q0.push_back(8'hA5);
    for (int k = 0; k <= 101; k++) begin
      if (k > 0) cycle();
      if (k < 100) begin
        expb = frame_bit(8'hA5, 0, 0, k / DIV);
        checks++;
        if (b0.tx_serial !== expb) begin
          errors++; $display("FAIL single_serial cycle %0d got %b expected %b", k, b0.tx_serial, expb);
        end
        if (b0.tx_done !== 1'b0 || b0.tx_ready !== 1'b0 || b0.tx_busy !== 1'b1) bad_ctl = 1'b1;
      end else if (k == 100) begin
        checks++;
        if (b0.tx_done !== 1'b1 || b0.tx_ready !== 1'b1 || b0.tx_busy !== 1'b0) begin
          errors++; $display("FAIL single_end got done=%b ready=%b busy=%b expected 1 1 0", b0.tx_done, b0.tx_ready, b0.tx_busy);
        end
      end else begin
        checks++;
        if (b0.tx_done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b expected 0", b0.tx_done); end
      end
    end
    checks++;
    if (bad_ctl) begin errors++; $display("FAIL single_ctl_during_frame got 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    int   t1;
    int   t2;
    logic ser_at[0:220];
    logic rdy_at[0:220];
    t1 = -1;
    t2 = -1;
    b0.tx_data  = 8'h00;
    b0.tx_valid = 1'b1;
    cycle();
    q0.push_back(8'h00);
    b0.tx_data = 8'hFF;
    ser_at[0] = b0.tx_serial;
    rdy_at[0] = b0.tx_ready;
    for (int k = 1; k <= 220; k++) begin
      cycle();
      ser_at[k] = b0.tx_serial;
      rdy_at[k] = b0.tx_ready;
      if (b0.tx_done === 1'b1) begin
        if (t1 < 0) begin
          t1 = k;
          q0.push_back(8'hFF);
        end else begin
          t2 = k;
          b0.tx_valid = 1'b0;
          break;
        end
      end
    end
    b0.tx_valid = 1'b0;
    checks++; if (t1 != 100) begin errors++; $display("FAIL b2b_first_done got %0d expected 100", t1); end
    checks++; if (t2 - t1 != 101) begin errors++; $display("FAIL b2b_done_spacing got %0d expected 101", t2 - t1); end
    if (t1 > 0 && t1 < 219) begin
      checks++; if (ser_at[t1] !== 1'b1) begin errors++; $display("FAIL b2b_idle_cycle got %b expected 1", ser_at[t1]); end
      checks++; if (ser_at[t1+1] !== 1'b0) begin errors++; $display("FAIL b2b_next_start got %b expected 0", ser_at[t1+1]); end
      checks++; if (rdy_at[t1+1] !== 1'b0) begin errors++; $display("FAIL b2b_ready_after got %b expected 0", rdy_at[t1+1]); end
    end
    cycle();
    checks++; if (b0.tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after got %b expected 1", b0.tx_ready); end
  endtask

  task automatic test_parity();
    logic bad_done;
    logic e1;
    logic e2;
    bad_done    = 1'b0;
    b1.tx_data  = 8'h07;
    b2.tx_data  = 8'h07;
    b1.tx_valid = 1'b1;
    b2.tx_valid = 1'b1;
    cycle();
    b1.tx_valid = 1'b0;
    b2.tx_valid = 1'b0;
    for (int k = 0; k <= 110; k++) begin
      if (k > 0) cycle();
      if (k < 110) begin
        e1 = frame_bit(8'h07, 1, 0, k / DIV);
        e2 = frame_bit(8'h07, 1, 1, k / DIV);
        checks++;
        if (b1.tx_serial !== e1 || b2.tx_serial !== e2) begin
          errors++; $display("FAIL parity_serial cycle %0d got even=%b odd=%b expected %b %b", k, b1.tx_serial, b2.tx_serial, e1, e2);
        end
        if (b1.tx_done !== 1'b0 || b2.tx_done !== 1'b0) bad_done = 1'b1;
      end
      if (k == 95) begin
        checks++; if (b1.tx_serial !== 1'b1) begin errors++; $display("FAIL parity_even_bit got %b expected 1", b1.tx_serial); end
        checks++; if (b2.tx_serial !== 1'b0) begin errors++; $display("FAIL parity_odd_bit got %b expected 0", b2.tx_serial); end
      end
      if (k == 110) begin
        checks++;
        if (b1.tx_done !== 1'b1 || b2.tx_done !== 1'b1) begin
          errors++; $display("FAIL parity_frame_len got done even=%b odd=%b expected 1 1", b1.tx_done, b2.tx_done);
        end
      end
    end
    checks++;
    if (bad_done) begin errors++; $display("FAIL parity_early_done got 1 expected 0"); end
  endtask

  task automatic test_stop_bits();
    logic bad_ready;
    logic expb;
    bad_ready   = 1'b0;
    b3.tx_data  = 8'h55;
    b3.tx_valid = 1'b1;
    cycle();
    b3.tx_valid = 1'b0;
    for (int k = 0; k <= 110; k++) begin
      if (k > 0) cycle();
      if (k < 110) begin
        expb = frame_bit(8'h55, 0, 0, k / DIV);
        checks++;
        if (b3.tx_serial !== expb) begin
          errors++; $display("FAIL stop2_serial cycle %0d got %b expected %b", k, b3.tx_serial, expb);
        end
        if (b3.tx_ready !== 1'b0 || b3.tx_done !== 1'b0) bad_ready = 1'b1;
      end else begin
        checks++;
        if (b3.tx_done !== 1'b1 || b3.tx_ready !== 1'b1) begin
          errors++; $display("FAIL stop2_end got done=%b ready=%b expected 1 1", b3.tx_done, b3.tx_ready);
        end
      end
    end
    checks++;
    if (bad_ready) begin errors++; $display("FAIL stop2_ready_low got early ready/done expected none"); end
  endtask

  task automatic test_loopback();
    logic [7:0] pat[4];
    int         lat;
    int         base;
    pat[0] = 8'h00;
    pat[1] = 8'h55;
    pat[2] = 8'hAA;
    pat[3] = 8'hFF;
    base = rx_frames;
    for (int i = 0; i < 4; i++) begin
      send0(pat[i], lat);
      checks++;
      if (lat != 100) begin errors++; $display("FAIL loopback_latency byte %02h got %0d expected 100", pat[i], lat); end
    end
    repeat (5) cycle();
    checks++; if (rx_frames - base != 4) begin errors++; $display("FAIL loopback_frames got %0d expected 4", rx_frames - base); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d expected 0", q0.size()); end
  endtask

  initial begin
    b0.tx_data = '0; b0.tx_valid = 1'b0;
    b1.tx_data = '0; b1.tx_valid = 1'b0;
    b2.tx_data = '0; b2.tx_valid = 1'b0;
    b3.tx_data = '0; b3.tx_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_stop_bits();
    test_loopback();
    repeat (5) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
